// File: rtl/spi_slave_if.sv
// spi_slave_if -- serial front end of the SPI slave.
//
// Shifts MOSI in MSB first and assembles 10-bit words {opcode[1:0], payload[7:0]}
// for the downstream memory block (rx_data / rx_valid). For read-data frames it
// takes the 8-bit word the memory block returns (tx_data / tx_valid) and shifts
// it out on MISO, MSB first. Everything runs on the rising edge of the SPI clock.
//
// Ports:
//   clk       in   SPI serial clock, rising edge active
//   rst       in   synchronous reset, active high
//   SS_n      in   slave select, active low frame enable
//   MOSI      in   serial data from master
//   MISO      out  serial data to master
//   rx_data   out  received word {opcode, payload}
//   rx_valid  out  one-cycle strobe marking rx_data valid
//   tx_data   in   read data from the memory block
//   tx_valid  in   memory block accepted a read-data opcode
//   frame_err out  (only with SPI_FRAME_ERR_EN) one-cycle pulse on an aborted frame
//
// Optional feature macro: SPI_FRAME_ERR_EN adds the frame_err output.

module spi_slave_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic               frame_err
`endif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  // The bit counter keeps running past the end of the frame so that it also
  // times the read-data return path:
  //   1..9  bits received so far, 10 = frame complete (cycle R),
  //   11    = cycle R+1 (tx_data load at its end),
  //   12..19 = MISO output cycles R+2..R+9, 20 = finished (saturates).
  localparam logic [4:0] CNT_LAST_BIT = 5'd9;
  localparam logic [4:0] CNT_DONE     = 5'd10;
  localparam logic [4:0] CNT_LOAD     = 5'd11;
  localparam logic [4:0] CNT_OUT_FIRST = 5'd12;
  localparam logic [4:0] CNT_OUT_LAST  = 5'd19;
  localparam logic [4:0] CNT_END      = 5'd20;

  logic [2:0]         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [FRAME_W-2:0] shift_q, shift_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic               tx_go_q, tx_go_d;
  logic               miso_q, miso_d;
`ifdef SPI_FRAME_ERR_EN
  logic               frame_err_q, frame_err_d;
`endif

  // Next-state logic. A deselect (SS_n high) in any active state takes
  // priority over everything else and drops the partial frame; the
  // rd_addr flag and the last rx_data are left untouched by an abort.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    tx_shift_d = tx_shift_q;
    tx_go_d    = tx_go_q;
    miso_d     = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif

    if (state_q != IDLE && SS_n) begin
      state_d    = IDLE;
      cnt_d      = '0;
      tx_shift_d = '0;
      tx_go_d    = 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_d = (cnt_q < CNT_DONE) ||
                    (state_q == READ_DATA && tx_go_q &&
                     cnt_q >= CNT_LOAD && cnt_q < CNT_END);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!SS_n) begin
            state_d    = CHK_CMD;
            cnt_d      = '0;
            tx_shift_d = '0;
            tx_go_d    = 1'b0;
          end
        end

        // Bit 9 picks the path; the read path depends on whether an
        // address frame has already been seen.
        CHK_CMD: begin
          shift_d = {{(FRAME_W-2){1'b0}}, MOSI};
          cnt_d   = 5'd1;
          if (!MOSI)
            state_d = WRITE;
          else if (!rd_addr_q)
            state_d = READ_ADD;
          else
            state_d = READ_DATA;
        end

        default: begin
          if (cnt_q < CNT_LAST_BIT) begin
            shift_d = {shift_q[FRAME_W-3:0], MOSI};
            cnt_d   = cnt_q + 5'd1;
          end else if (cnt_q == CNT_LAST_BIT) begin
            rx_data_d  = {shift_q, MOSI};
            rx_valid_d = 1'b1;
            cnt_d      = CNT_DONE;
            if (shift_q[FRAME_W-2 -: 2] == 2'b10)
              rd_addr_d = 1'b1;
            else if (shift_q[FRAME_W-2 -: 2] == 2'b11)
              rd_addr_d = 1'b0;
          end else if (cnt_q < CNT_END) begin
            cnt_d = cnt_q + 5'd1;
          end

          // Return path: tx_valid is looked at during R, the memory's
          // registered data is captured one cycle later, then shifted out.
          if (state_q == READ_DATA) begin
            if (cnt_q == CNT_DONE)
              tx_go_d = tx_valid;
            if (cnt_q == CNT_LOAD && tx_go_q)
              tx_shift_d = tx_data;
            else if (cnt_q >= CNT_OUT_FIRST && cnt_q < CNT_END)
              tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end

          if (state_q == READ_DATA && cnt_d >= CNT_OUT_FIRST && cnt_d <= CNT_OUT_LAST)
            miso_d = tx_shift_d[DATA_W-1];
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_addr_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_go_q    <= 1'b0;
      miso_q     <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_addr_q  <= rd_addr_d;
      tx_shift_q <= tx_shift_d;
      tx_go_q    <= tx_go_d;
      miso_q     <= miso_d;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`ifdef SPI_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if -- self-checking bench for spi_slave_if.
//
// Drives whole SPI frames (complete or cut short) and compares rx_valid,
// rx_data, MISO (and frame_err when SPI_FRAME_ERR_EN is defined) after every
// clock edge against expectations derived frame by frame: a complete frame
// produces its word one cycle after its tenth data edge, a read-data frame
// with tx_valid returns tx_data on MISO in the eight cycles starting two
// cycles after that, and the read-address flag follows the received opcodes.

module tb_spi_slave_if;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic               frame_err;
  bit                 expErr;
`endif

  int checkCount = 0;
  int errorCount = 0;

  // Reference state: the flag that decides read-data framing, and the last
  // word the slave should be presenting on rx_data.
  bit                 modelRdAddr = 1'b0;
  logic [FRAME_W-1:0] modelRxData = '0;

  spi_slave_if #(.FRAME_W(FRAME_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Safety net in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Take one rising edge, then compare all outputs a little after it.
  task automatic stepAndCheck(input string tag, input bit expValid, input bit expMiso);
    @(posedge clk);
    #1;
    checkOutput({tag, ".rx_valid"}, 32'(rx_valid), 32'(expValid));
    checkOutput({tag, ".rx_data"}, 32'(rx_data), 32'(modelRxData));
    checkOutput({tag, ".miso"}, 32'(MISO), 32'(expMiso));
`ifdef SPI_FRAME_ERR_EN
    checkOutput({tag, ".frame_err"}, 32'(frame_err), 32'(expErr));
    expErr = 1'b0;
`endif
  endtask

  // Hold reset for n edges with the slave selected and MOSI high.
  task automatic applyReset(input int n);
    rst  = 1'b1;
    SS_n = 1'b0;
    MOSI = 1'b1;
    modelRxData = '0;
    modelRdAddr = 1'b0;
    for (int i = 0; i < n; i++)
      stepAndCheck("reset", 1'b0, 1'b0);
    rst  = 1'b0;
    SS_n = 1'b1;
  endtask

  // Idle cycles with the slave deselected; other inputs are noise.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      SS_n     = 1'b1;
      MOSI     = 1'($urandom);
      tx_valid = 1'($urandom);
      tx_data  = 8'($urandom);
      stepAndCheck("idle", 1'b0, 1'b0);
    end
  endtask

  // One frame. Edge 0 selects the slave, edges 1..10 carry word bits 9..0.
  // With nbits < 10 the slave is deselected at edge nbits+1 (abort);
  // otherwise SS_n stays low for tailLen extra cycles beyond the read return
  // window and the slave is deselected at edge 21+tailLen.
  task automatic applyStimulus(input logic [FRAME_W-1:0] word, input int nbits,
                               input bit txv, input logic [DATA_W-1:0] txd,
                               input int tailLen);
    bit isRead;
    bit full;
    int lastEdge;
    isRead   = word[9] && modelRdAddr;
    full     = (nbits >= 10);
    lastEdge = full ? 21 + tailLen : nbits + 1;
    for (int j = 0; j <= lastEdge; j++) begin
      bit expValid;
      bit expMiso;
      expValid = 1'b0;
      expMiso  = 1'b0;
      SS_n     = (j == lastEdge);
      MOSI     = (j >= 1 && j <= 10 && j <= nbits) ? word[10-j] : 1'($urandom);
      tx_valid = (j == 11) ? txv : 1'($urandom);
      tx_data  = (j == 12) ? txd : 8'($urandom);
      if (full && j == 10) begin
        expValid    = 1'b1;
        modelRxData = word;
        if (word[9:8] == 2'b10)
          modelRdAddr = 1'b1;
        else if (word[9:8] == 2'b11)
          modelRdAddr = 1'b0;
      end
      if (full && isRead && txv && j >= 12 && j <= 19)
        expMiso = txd[19-j];
`ifdef SPI_FRAME_ERR_EN
      expErr = (!full && j == lastEdge);
`endif
      stepAndCheck(full ? "frame" : "abort", expValid, expMiso);
    end
  endtask

  initial begin
    rst      = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
`ifdef SPI_FRAME_ERR_EN
    expErr   = 1'b0;
`endif
    #1;

    // Reset with the bus active, then the directed scenarios.
    applyReset(2);
    idleCycles(1);
    applyStimulus(10'h0A5, 10, 1'b0, 8'h00, 3);
    idleCycles(2);
    applyStimulus(10'h13C, 10, 1'b0, 8'h00, 0);
    applyStimulus(10'h2A5, 10, 1'b0, 8'h00, 0);
    applyStimulus(10'h300, 10, 1'b1, 8'hC3, 1);

    // Abort after five bits must leave the read-address flag set, so the
    // following 11 frame still returns data.
    applyStimulus(10'h2A5, 10, 1'b0, 8'h00, 0);
    applyStimulus(10'h300, 5, 1'b1, 8'h5A, 0);
    applyStimulus(10'h300, 10, 1'b1, 8'h96, 0);

    // Read frame with tx_valid low: nothing shifted out.
    applyStimulus(10'h2A5, 10, 1'b0, 8'h00, 0);
    applyStimulus(10'h3FF, 10, 1'b0, 8'hFF, 0);

    // Back-to-back writes with the minimum one-cycle gap.
    applyStimulus(10'h0F0, 10, 1'b0, 8'h00, 0);
    applyStimulus(10'h10F, 10, 1'b0, 8'h00, 0);

    // Reset in the middle of a frame discards it and clears everything.
    applyStimulus(10'h2AA, 10, 1'b0, 8'h00, 0);
    SS_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'($urandom);
      stepAndCheck("midframe", 1'b0, 1'b0);
    end
    applyReset(1);
    applyStimulus(10'h355, 10, 1'b1, 8'hA5, 0);

    // Randomized frames, some cut short, with random gaps.
    for (int n = 0; n < 150; n++) begin
      logic [FRAME_W-1:0] w;
      int nb;
      w  = 10'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 10;
      applyStimulus(w, nb, 1'($urandom), 8'($urandom), $urandom_range(0, 2));
      idleCycles($urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
